// File: rtl/vend_dispense_ctrl_if.sv
// Signal bundle between the vending core/dispense mechanics and vend_dispense_ctrl.
// master: the environment (core requests and sensors); slave: the controller.
interface vend_dispense_ctrl_if;
    logic       out;
    logic [1:0] change;
    logic       drop_sense;
    logic       coin_sense;
    logic       motor_on;
    logic       hopper_pulse;
    logic       busy;
    logic       q_full;
    logic       overflow;
    logic       fault;

    modport master (
        output out, change, drop_sense, coin_sense,
        input  motor_on, hopper_pulse, busy, q_full, overflow, fault
    );

    modport slave (
        input  out, change, drop_sense, coin_sense,
        output motor_on, hopper_pulse, busy, q_full, overflow, fault
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: queues vend/change transactions from the vending core and
// drives the product motor and coin hopper, waiting on sensor acknowledgement.
// Optional feature macro DISPENSE_TIMEOUT_EN: adds a sensor-wait timeout that
// parks the block in FAULT; without it the sensor waits are unbounded and
// fault is tied low.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | no transaction in progress; pops the queue head when present
// MOTOR       | motor running, waiting for drop_sense
// HOPPER      | eject solenoid pulsed for PULSE_LEN cycles
// HOPPER_WAIT | waiting for coin_sense for the coin just ejected
// FAULT       | sensor timeout; actuators off, left only through rst
module vend_dispense_ctrl #(
    parameter int QDEPTH    = 4,
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    vend_dispense_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_MOTOR       = 3'd1;
    localparam logic [2:0] S_HOPPER      = 3'd2;
    localparam logic [2:0] S_HOPPER_WAIT = 3'd3;
    localparam logic [2:0] S_FAULT       = 3'd4;

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PLS_W = $clog2(PULSE_LEN + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
    localparam logic [PLS_W-1:0] PLS_LOAD = PLS_W'(PULSE_LEN - 1);

    // Parameter sanity, caught at elaboration rather than as odd behaviour.
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("QDEPTH must be a power of two >= 2");
    end
    if (PULSE_LEN < 1) begin : g_bad_pulse
        $error("PULSE_LEN must be >= 1");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be >= 2");
    end

    // Queue entry layout: {vend, coins[1:0]}
    logic [2:0]       mem_q [QDEPTH];
    logic [2:0]       mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [2:0]       state_q, state_d;
    logic [1:0]       coins_q, coins_d;
    logic [PLS_W-1:0] pulse_cnt_q, pulse_cnt_d;

    logic motor_on_q, motor_on_d;
    logic hopper_pulse_q, hopper_pulse_d;
    logic busy_q, busy_d;
    logic q_full_q, q_full_d;
    logic overflow_q, overflow_d;
    logic fault_q, fault_d;

    logic       txn_valid;
    logic       q_is_full;
    logic       q_is_empty;
    logic       push;
    logic       pop;
    logic [2:0] head;
    logic       tmo_expired;

    assign txn_valid  = bus.out | (bus.change != 2'b00);
    assign q_is_full  = (count_q == FULL_CNT);
    assign q_is_empty = (count_q == '0);
    // Fullness is judged at the start of the cycle, so a same-cycle pop never
    // makes room for the incoming entry.
    assign push       = txn_valid & ~q_is_full;
    assign head       = mem_q[rd_ptr_q];

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_entry;

    assign tmo_entry   = (state_d != state_q) &&
                         ((state_d == S_MOTOR) || (state_d == S_HOPPER_WAIT));
    // Terminal count reached on the TIMEOUT-th sensor-wait cycle.
    assign tmo_expired = (tmo_cnt_q == '0);

    // Down-counter reloaded on entry to a sensor wait, counts while waiting.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (tmo_entry) begin
            tmo_cnt_d = TMO_LOAD;
        end else if (((state_q == S_MOTOR) || (state_q == S_HOPPER_WAIT)) &&
                     (tmo_cnt_q != '0)) begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_expired = 1'b0;
`endif

    // Dispense sequencing: pop, motor, then one pulse/ack round per coin.
    always_comb begin
        state_d     = state_q;
        coins_d     = coins_q;
        pulse_cnt_d = pulse_cnt_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!q_is_empty) begin
                    pop     = 1'b1;
                    coins_d = head[1:0];
                    if (head[2]) begin
                        state_d = S_MOTOR;
                    end else begin
                        state_d     = S_HOPPER;
                        pulse_cnt_d = PLS_LOAD;
                    end
                end
            end
            S_MOTOR: begin
                if (bus.drop_sense) begin
                    if (coins_q != 2'd0) begin
                        state_d     = S_HOPPER;
                        pulse_cnt_d = PLS_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_HOPPER: begin
                if (pulse_cnt_q == '0) begin
                    state_d = S_HOPPER_WAIT;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - 1'b1;
                end
            end
            S_HOPPER_WAIT: begin
                if (bus.coin_sense) begin
                    coins_d = coins_q - 2'd1;
                    if (coins_q == 2'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_HOPPER;
                        pulse_cnt_d = PLS_LOAD;
                    end
                end else if (tmo_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Circular queue bookkeeping; a push while full is dropped and flagged.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d = overflow_q | (txn_valid & q_is_full);
        if (push) begin
            mem_d[wr_ptr_q] = {bus.out, bus.change};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Registered outputs decoded from the next state and next occupancy.
    always_comb begin
        motor_on_d     = (state_d == S_MOTOR);
        hopper_pulse_d = (state_d == S_HOPPER);
        busy_d         = (count_d != '0) || (state_d != S_IDLE);
        q_full_d       = (count_d == FULL_CNT);
`ifdef DISPENSE_TIMEOUT_EN
        fault_d        = (state_d == S_FAULT);
`else
        fault_d        = 1'b0;
`endif
    end

    // State, queue and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            coins_q        <= '0;
            pulse_cnt_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            motor_on_q     <= 1'b0;
            hopper_pulse_q <= 1'b0;
            busy_q         <= 1'b0;
            q_full_q       <= 1'b0;
            overflow_q     <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            coins_q        <= coins_d;
            pulse_cnt_q    <= pulse_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            mem_q          <= mem_d;
            motor_on_q     <= motor_on_d;
            hopper_pulse_q <= hopper_pulse_d;
            busy_q         <= busy_d;
            q_full_q       <= q_full_d;
            overflow_q     <= overflow_d;
            fault_q        <= fault_d;
        end
    end

    assign bus.motor_on     = motor_on_q;
    assign bus.hopper_pulse = hopper_pulse_q;
    assign bus.busy         = busy_q;
    assign bus.q_full       = q_full_q;
    assign bus.overflow     = overflow_q;
    assign bus.fault        = fault_q;

endmodule

// File: doc/vend_dispense_ctrl.md
# vend_dispense_ctrl

Downstream executor for the vending machine FSM: consumes its `out` (vend) and `change` outputs, queues each transaction, and drives the product motor and coin-hopper actuators with sensor acknowledgement. Sits between the vending machine core and the physical dispense mechanics; the core never stalls, so this block buffers bursts and reports overflow and fault status.

## Interface
Parameters:
- `QDEPTH`, 4: transaction queue depth; power of two, ≥2.
- `PULSE_LEN`, 4: hopper eject pulse width in cycles; ≥1.
- `TIMEOUT`, 1000: cycles allowed for a sensor acknowledgement; ≥2. Used only with `DISPENSE_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous reset, active-high.
- `out` in 1: vend request from the vending machine; one transaction per cycle high.
- `change` in 2: change code from the vending machine, sampled the same cycle as `out`. 00 none, 01/10/11 = 1/2/3 coins of 5 units.
- `drop_sense` in 1: product-drop sensor, high ≥1 cycle per product.
- `coin_sense` in 1: hopper coin-exit sensor, high ≥1 cycle per coin.
- `motor_on` out 1: product motor drive.
- `hopper_pulse` out 1: hopper eject solenoid.
- `busy` out 1: queue non-empty or state ≠ IDLE.
- `q_full` out 1: queue holds `QDEPTH` entries.
- `overflow` out 1: sticky; a transaction was dropped.
- `fault` out 1: sticky; sensor timeout occurred.

## Operation
- Transaction = `{vend, coins[1:0]}` captured in any cycle where `out`=1 or `change`≠00. Cycles with both zero push nothing.
- Push when queue not full at the start of the cycle (same-cycle pop does not free space for that push). Push while full: entry dropped, `overflow` set.
- States: IDLE, MOTOR, HOPPER, HOPPER_WAIT, FAULT.
- IDLE: queue non-empty → pop head into `vend_r`, `coins_r`; vend=1 → MOTOR; else → HOPPER.
- MOTOR: `motor_on`=1; `drop_sense` high → HOPPER if `coins_r`≠0, else IDLE.
- HOPPER: `hopper_pulse`=1 for exactly `PULSE_LEN` cycles → HOPPER_WAIT.
- HOPPER_WAIT: `coin_sense` high → decrement `coins_r`; result 0 → IDLE, else → HOPPER.
- Sensors sampled only in MOTOR (`drop_sense`) and HOPPER_WAIT (`coin_sense`); ignored elsewhere, including `coin_sense` during HOPPER.
- FAULT: `motor_on`=`hopper_pulse`=0, `fault`=1; queue still accepts/drops; exit only via `rst`.
- All outputs registered (Moore on state).
- Queue: circular, read/write pointers `log2(QDEPTH)` bits, wrap modulo `QDEPTH`; separate occupancy count 0..`QDEPTH`.

## Timing
- Reset: all outputs 0, queue empty, state IDLE, counters 0; takes effect at the first edge with `rst`=1, mid-operation included (actuators drop the following cycle).
- `out` high in cycle N, idle block: entry pushed at end of N; popped end of N+1; `motor_on` high from N+2.
- Change-only transaction: `hopper_pulse` high from N+2 for `PULSE_LEN` cycles.
- `drop_sense` high in cycle M (MOTOR): `motor_on` low from M+1; `hopper_pulse` high from M+1 if coins pending.
- `coin_sense` in cycle M (HOPPER_WAIT): next pulse starts M+1, or IDLE at M+1.
- Back-to-back transactions: IDLE occupies one cycle between them.
- `busy` high from N+1 until the cycle after returning to IDLE with empty queue.

## Configuration
- `DISPENSE_TIMEOUT_EN` defined: cycle counter cleared on entry to MOTOR/HOPPER_WAIT; reaching `TIMEOUT` cycles without the sensor → FAULT next cycle.
- Undefined: no counter; MOTOR and HOPPER_WAIT wait indefinitely; `fault` tied 0.

## Test plan
- Reset then `out`=1,`change`=00 one cycle at t=N -> `motor_on` high from N+2; `drop_sense` pulse -> `motor_on` low next cycle, no hopper pulse, `busy` low after.
- `out`=1,`change`=10 -> motor, then after `drop_sense` exactly two 4-cycle `hopper_pulse` bursts, each awaiting `coin_sense`; IDLE after second coin.
- `change`=01 only -> one 4-cycle hopper pulse starting N+2, no `motor_on`.
- 6 consecutive `out` pulses with sensors held low, `QDEPTH`=4 -> first popped, 4 queued, `q_full`=1, one dropped, `overflow`=1 sticky until `rst`.
- With `DISPENSE_TIMEOUT_EN`, `TIMEOUT`=20, no `drop_sense` -> FAULT at 20 cycles, `motor_on`=0, `fault`=1; `rst` clears all.
- `rst` asserted during hopper pulse -> `hopper_pulse` 0 next cycle, queue empty, `busy`=0.
